// File: rtl/point_match_scan_if.sv
// ============================================================================
//  point_match_scan_if
//  Beat input stream and frame result handshake bundle for point_match_scan.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface point_match_scan_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_hit_count;
  logic [CNT_W-1:0] out_first_idx;
  logic             out_any;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_hit_count, out_first_idx, out_any
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_hit_count, out_first_idx, out_any
  );
endinterface

`default_nettype wire

// File: rtl/point_match_scan.sv
// ============================================================================
//  point_match_scan
//  Counts beats per frame whose operands are exact bitwise complements and
//  reports the hit count and the index of the first hit.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module point_match_scan #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  point_match_scan_if.slave bus
);

  localparam int               c_pairs   = WIDTH / 2;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_hit_count;
  logic [CNT_W-1:0]   r_first_idx;
  logic               r_first_seen;
  logic [CNT_W-1:0]   r_beat_idx;
  logic               r_any;

  logic               r_s1_valid;
  logic               r_s1_last;
  logic [c_pairs-1:0] r_s1_pairs;
  logic               r_s2_valid;
  logic               r_s2_last;
  logic               r_s2_match;

  logic [WIDTH-1:0]   w_xor;
  logic [c_pairs-1:0] w_pairs;
  logic               w_accept;
  logic               w_hit_inc;
  logic [CNT_W-1:0]   w_hit_next;
  logic               w_first_take;

  assign w_xor    = bus.in_a ^ bus.in_b;
  assign w_accept = bus.in_valid && r_in_ready;

  generate
    for (genvar i = 0; i < c_pairs; i++) begin : g_pair
      assign w_pairs[i] = w_xor[2*i] & w_xor[2*i+1];
    end
  endgenerate

  // Two-stage reduction pipeline; only the valid bits need a reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pairs <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_match <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_last  <= bus.in_last;
        r_s1_pairs <= w_pairs;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s2_match <= &r_s1_pairs;
    end
  end

  assign w_hit_inc    = r_s2_valid && r_s2_match;
  assign w_hit_next   = (w_hit_inc && (r_hit_count != c_cnt_max)) ?
                        r_hit_count + 1'b1 : r_hit_count;
  assign w_first_take = w_hit_inc && !r_first_seen;

  // Frame FSM and accumulator; the HOLD release clears the accumulator last
  // so it wins over the (impossible in HOLD) consume path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACC;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_hit_count  <= '0;
      r_first_idx  <= c_cnt_max;
      r_first_seen <= 1'b0;
      r_beat_idx   <= '0;
      r_any        <= 1'b0;
    end else begin
      if (r_s2_valid) begin
        r_hit_count <= w_hit_next;
        r_any       <= (w_hit_next != '0);
        if (w_first_take) begin
          r_first_idx  <= r_beat_idx;
          r_first_seen <= 1'b1;
        end
        if (r_beat_idx != c_cnt_max) begin
          r_beat_idx <= r_beat_idx + 1'b1;
        end
      end

      case (r_state)
        ACC: begin
          if (w_accept && bus.in_last) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (r_s2_valid && r_s2_last) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state      <= ACC;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_hit_count  <= '0;
            r_first_idx  <= c_cnt_max;
            r_first_seen <= 1'b0;
            r_beat_idx   <= '0;
            r_any        <= 1'b0;
          end
        end
        default: begin
          r_state     <= ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_hit_count = r_hit_count;
  assign bus.out_first_idx = r_first_idx;
  assign bus.out_any       = r_any;

endmodule

`default_nettype wire

// File: tb/tb_point_match_scan.sv
// ============================================================================
//  tb_point_match_scan
//  Directed and random frames checked against a frame-level reference model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_point_match_scan;

  localparam int W  = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  point_match_scan_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  point_match_scan #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int hit; int first; int any;} res_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   rmode = 1'b0;
  bit   busy = 1'b0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   f_cnt = 0;
  int   f_hits = 0;
  int   f_first = -1;
  int   frames_done = 0;
  res_t expq[$];

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Reference model: a frame is a list of beats; the result depends only on
  // how many beats were complementary and where the first one sat.
  always @(negedge clk) begin
    bit   vis;
    bit   m;
    res_t r;
    if (chk_en) begin
      cyc++;
      vis = busy && (cyc - last_cyc >= 3);
      chk("in_ready", int'(bus.in_ready), int'(!busy));
      chk("out_valid", int'(bus.out_valid), int'(vis));
      if (vis && expq.size() > 0) begin
        chk("hit_count", int'(bus.out_hit_count), expq[0].hit);
        chk("first_idx", int'(bus.out_first_idx), expq[0].first);
        chk("any", int'(bus.out_any), expq[0].any);
      end
      if (rst) begin
        busy = 1'b0;
        expq.delete();
        f_cnt = 0; f_hits = 0; f_first = -1;
      end else if (!busy && bus.in_valid) begin
        m = ((bus.in_a ^ bus.in_b) == {W{1'b1}});
        if (m) begin
          if (f_hits == 0) f_first = f_cnt;
          f_hits++;
        end
        f_cnt++;
        if (bus.in_last) begin
          r.hit   = (f_hits > CMAX) ? CMAX : f_hits;
          r.first = (f_hits == 0 || f_first > CMAX) ? CMAX : f_first;
          r.any   = (f_hits > 0) ? 1 : 0;
          expq.push_back(r);
          busy = 1'b1;
          last_cyc = cyc;
          f_cnt = 0; f_hits = 0; f_first = -1;
        end
      end else if (vis && bus.out_ready) begin
        busy = 1'b0;
        if (expq.size() > 0) void'(expq.pop_front());
        frames_done++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rmode) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic last, input int gap);
    bit ok;
    int t;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    ok = 1'b0; t = 0;
    while (!ok && t < 200) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1; t++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  // Returns aligned to a negedge with out_valid high; lat counts negedges
  // after the one following the last accepting edge.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("result_seen", int'(bus.out_valid), 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int   lat;
    int   t;
    int   nf;
    int   len;
    int   kind;
    logic [W-1:0] a, b;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_hit_count", int'(bus.out_hit_count), 0);
    chk("rst_first_idx", int'(bus.out_first_idx), 255);
    chk("rst_any", int'(bus.out_any), 0);
    chk_en = 1'b1;

    // Three beats: match, no match, match
    send_beat(16'h00FF, 16'hFF00, 1'b0, 0);
    send_beat(16'h1234, 16'h1234, 1'b0, 0);
    send_beat(16'hAAAA, 16'h5555, 1'b1, 0);
    wait_result(lat);
    chk("f1_latency", lat, 2);
    chk("f1_hit", int'(bus.out_hit_count), 2);
    chk("f1_first", int'(bus.out_first_idx), 0);
    chk("f1_any", int'(bus.out_any), 1);
    @(posedge clk); #1;

    // Four beats with a == b: nothing matches
    for (int i = 0; i < 4; i++) send_beat(16'(i * 16'h1111), 16'(i * 16'h1111), 1'(i == 3), 0);
    wait_result(lat);
    chk("f2_hit", int'(bus.out_hit_count), 0);
    chk("f2_first", int'(bus.out_first_idx), 255);
    chk("f2_any", int'(bus.out_any), 0);
    @(posedge clk); #1;

    // Single-beat frame with the result held back for 5 cycles
    bus.out_ready = 1'b0;
    send_beat(16'hF0F0, 16'h0F0F, 1'b1, 0);
    wait_result(lat);
    chk("f3_hit", int'(bus.out_hit_count), 1);
    chk("f3_first", int'(bus.out_first_idx), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("f3_hold_valid", int'(bus.out_valid), 1);
      chk("f3_hold_in_ready", int'(bus.in_ready), 0);
      chk("f3_hold_any", int'(bus.out_any), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 5) begin @(posedge clk); #1; t++; end
    chk("f3_release_acc", int'(bus.in_ready), 1);

    // 300 matching beats saturate the hit counter
    for (int i = 0; i < 300; i++) send_beat(16'(i), ~16'(i), 1'(i == 299), 0);
    wait_result(lat);
    chk("f4_hit_sat", int'(bus.out_hit_count), 255);
    chk("f4_first", int'(bus.out_first_idx), 0);
    @(posedge clk); #1;

    // First match at beat 260: index is already saturated
    for (int i = 0; i < 261; i++) send_beat(16'h0042, (i == 260) ? 16'hFFBD : 16'h0042, 1'(i == 260), 0);
    wait_result(lat);
    chk("f5_hit", int'(bus.out_hit_count), 1);
    chk("f5_first_sat", int'(bus.out_first_idx), 255);
    chk("f5_any", int'(bus.out_any), 1);
    @(posedge clk); #1;

    // Reset while the matching last beat is still in the pipeline
    send_beat(16'hF0F0, 16'h0F0F, 1'b1, 0);
    pulse_rst();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_drain_no_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    send_beat(16'h1111, 16'h1111, 1'b0, 0);
    send_beat(16'h1111, 16'hEEEE, 1'b1, 1);
    wait_result(lat);
    chk("f6_hit", int'(bus.out_hit_count), 1);
    chk("f6_first", int'(bus.out_first_idx), 1);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial frame
    send_beat(16'h0001, 16'hFFFE, 1'b0, 0);
    send_beat(16'h0002, 16'hFFFD, 1'b0, 0);
    pulse_rst();
    send_beat(16'h0003, 16'h0003, 1'b1, 2);
    wait_result(lat);
    chk("f7_hit", int'(bus.out_hit_count), 0);
    chk("f7_first", int'(bus.out_first_idx), 255);
    @(posedge clk); #1;

    // Random frames, random gaps, random backpressure
    nf = frames_done;
    rmode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        a = W'($urandom);
        kind = $urandom_range(0, 3);
        b = (kind < 2) ? ~a : (kind == 2) ? a : W'($urandom);
        send_beat(a, b, 1'(i == len - 1), $urandom_range(0, 2));
      end
    end
    rmode = 1'b0;
    #2;
    bus.out_ready = 1'b1;
    t = 0;
    while (busy && t < 50) begin @(posedge clk); #1; t++; end
    chk("random_drained", int'(busy), 0);
    chk("random_frames", frames_done - nf, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/point_match_scan.md
POINT_MATCH_SCAN -- requirements
Module: point_match_scan

Interface
- REQ-001: Parameter WIDTH, default 16, meaning operand width; SHALL be a power of two in 2..64.
- REQ-002: Parameter CNT_W, default 8, meaning width of the hit counter and the beat index.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: in_valid  input  1  input beat offered.
- REQ-006: in_ready  output  1  input beat can be accepted.
- REQ-007: in_a  input  WIDTH  operand A.
- REQ-008: in_b  input  WIDTH  operand B.
- REQ-009: in_last  input  1  marks the final beat of a frame.
- REQ-010: out_valid  output  1  frame result available.
- REQ-011: out_ready  input  1  downstream accepts the result.
- REQ-012: out_hit_count  output  CNT_W  number of matching beats in the frame.
- REQ-013: out_first_idx  output  CNT_W  0-based index of the first matching beat.
- REQ-014: out_any  output  1  at least one beat in the frame matched.

Function
- REQ-015: A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
- REQ-016: The match for an accepted beat SHALL be the AND-reduction over all bits of (in_a XOR in_b), i.e. match=1 iff in_a == ~in_b.
- REQ-017: Pipeline stage 1 SHALL register the pairwise ANDs of the XOR bits (WIDTH/2 bits), a valid bit, and the last flag, on the accepting edge N.
- REQ-018: Stage 2 SHALL register the full reduction, valid, and last on edge N+1.
- REQ-019: The accumulator SHALL consume the stage-2 beat on edge N+2.
- REQ-020: The FSM SHALL have exactly three states: ACC, DRAIN, HOLD.
- REQ-021: in_ready SHALL be 1 only in ACC.
- REQ-022: out_valid SHALL be 1 only in HOLD.
- REQ-023: ACC -> DRAIN on acceptance of a beat with in_last=1.
- REQ-024: DRAIN -> HOLD on the edge on which the accumulator consumes the last beat; a result therefore becomes visible 2 edges after the edge that accepted the last beat.
- REQ-025: HOLD -> ACC on an edge with out_ready=1.
- REQ-026: On the HOLD -> ACC edge, the accumulator, beat index, and first-hit flag SHALL clear for the next frame.
- REQ-027: out_hit_count, out_first_idx, and out_any SHALL remain stable throughout HOLD until the handshake.
- REQ-028: The beat index SHALL start at 0 per frame, increment per consumed beat, and saturate at 2^CNT_W-1 without wrapping.
- REQ-029: out_hit_count SHALL increment per matching beat and saturate at 2^CNT_W-1.
- REQ-030: out_first_idx SHALL capture the beat index of the first matching beat in the frame.
- REQ-031: out_first_idx SHALL be all-ones if the frame contains no match.
- REQ-032: If the first match occurs at a saturated index, out_first_idx SHALL equal all-ones while out_any=1.
- REQ-033: out_any SHALL equal (out_hit_count != 0).
- REQ-034: A single-beat frame (in_last on the first beat) SHALL be legal.
- REQ-035: in_valid gaps within a frame SHALL insert pipeline bubbles without affecting the counts.
- REQ-036: Beats SHALL NOT be accepted in DRAIN or HOLD; upstream holds its data.

Reset
- REQ-037: With rst=1 at an edge, the FSM SHALL go to ACC.
- REQ-038: With rst=1 at an edge, all pipeline valid bits, the accumulator, and the beat index SHALL clear to 0.
- REQ-039: Output reset values SHALL be: in_ready=1 (first cycle after reset), out_valid=0, out_hit_count=0, out_first_idx=all-ones, out_any=0.
- REQ-040: Reset asserted mid-frame, in DRAIN, or in HOLD SHALL discard the partial frame or pending result; no result for it SHALL appear.
- REQ-041: rst SHALL take priority over any simultaneous handshake.

Verification
- REQ-042: Stimulus: 3-beat frame with WIDTH=16, beats (0x00FF,0xFF00), (0x1234,0x1234), (0xAAAA,0x5555, last), out_ready=1. Required response: out_valid 2 edges after the last accept, hit_count=2, first_idx=0, any=1, return to ACC.
- REQ-043: Stimulus: frame of 4 beats with a==b throughout. Required response: hit_count=0, first_idx=0xFF, any=0.
- REQ-044: Stimulus: single-beat frame (0xF0F0,0x0F0F, last) with out_ready held 0 for 5 cycles. Required response: out_valid and outputs stable, in_ready=0 throughout; release -> ACC.
- REQ-045: Stimulus: 300 matching beats in one frame, CNT_W=8. Required response: hit_count=255 (saturated), first_idx=0.
- REQ-046: Stimulus: rst pulse while in DRAIN after a matching last beat. Required response: no out_valid; next frame reports only its own beats.
- REQ-047: Stimulus: random in_valid gaps and random out_ready. Required response: results match a reference model; no beat lost or duplicated.
